// File: rtl/mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// mdio_phy_responder
// PHY-side responder for Clause-22 MDIO management frames. MDC and MDIO_IN are
// oversampled on clk; frames addressed to PHY_ADDR read or write a local
// 32 x 16-bit register bank, and every committed write is also reported on
// the WR_* strobe bus.
//
// Ports
//   clk        system clock, all logic on posedge
//   RESET      asynchronous active-high reset
//   MDC        management clock from the station (asynchronous to clk)
//   MDIO_IN    serial data from the station
//   MDIO_OUT   serial read data towards the station
//   MDIO_OE    1 while the responder drives MDIO
//   WR_STROBE  1-clk pulse when a write commits
//   WR_ADDR    register address of the last committed write
//   WR_DATA    data of the last committed write
//   RD_STROBE  1-clk pulse when a read frame reaches turnaround
//   FRAME_ERR  1-clk pulse on a malformed write turnaround to PHY_ADDR
// -----------------------------------------------------------------------------
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR     = 5'd1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        WR_STROBE,
    output logic [4:0]  WR_ADDR,
    output logic [15:0] WR_DATA,
    output logic        RD_STROBE,
    output logic        FRAME_ERR
);

    localparam int               CNT_W   = (PREAMBLE_LEN < 2) ? 1 : $clog2(PREAMBLE_LEN + 1);
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PREAMBLE_LEN);

    typedef enum logic [3:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       mdc_sync_q, mdc_sync_d;
    logic [1:0]       mdio_sync_q, mdio_sync_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic             is_read_q, is_read_d;
    logic             first_bit_q, first_bit_d;
    logic [4:0]       phyad_q, phyad_d;
    logic [4:0]       regad_q, regad_d;
    logic [15:0]      shift_q, shift_d;
    logic             mdio_oe_q, mdio_oe_d;
    logic             mdio_out_q, mdio_out_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             rd_strobe_q, rd_strobe_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      bank_q [32];

    logic mdc_rise, mdc_fall, mdio_bit;

    // Two synchroniser stages, the third MDC stage only feeds the edge detector.
    assign mdc_sync_d  = {mdc_sync_q[1:0], MDC};
    assign mdio_sync_d = {mdio_sync_q[0], MDIO_IN};
    assign mdc_rise    = mdc_sync_q[1] & ~mdc_sync_q[2];
    assign mdc_fall    = ~mdc_sync_q[1] & mdc_sync_q[2];
    assign mdio_bit    = mdio_sync_q[1];

    always_comb begin
        // NOTE: every variable gets a default before the case; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        is_read_d   = is_read_q;
        first_bit_d = first_bit_q;
        phyad_d     = phyad_q;
        regad_d     = regad_q;
        shift_d     = shift_q;
        mdio_oe_d   = mdio_oe_q;
        mdio_out_d  = mdio_out_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_strobe_d = 1'b0;
        frame_err_d = 1'b0;

        if (mdc_rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + CNT_W'(1);
                    end else if (pre_cnt_q == PRE_MAX) begin
                        // Count saturates at PRE_MAX, so equality means "enough ones".
                        state_d   = S_ST;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = '0;
                    state_d   = mdio_bit ? S_OP : S_PRE;
                end
                S_OP: begin
                    if (bit_cnt_q == 5'd0) begin
                        first_bit_d = mdio_bit;
                        bit_cnt_d   = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        is_read_d = first_bit_q;
                        // Invalid opcodes drop silently: the target is unknown yet.
                        state_d   = (first_bit_q != mdio_bit) ? S_PHYAD : S_PRE;
                    end
                end
                S_PHYAD: begin
                    phyad_d = {phyad_q[3:0], mdio_bit};
                    if (bit_cnt_q == 5'd4) begin
                        if (phyad_d == PHY_ADDR) begin
                            state_d   = S_REGAD;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = S_SKIP;
                            bit_cnt_d = 5'd18;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_REGAD: begin
                    regad_d = {regad_q[3:0], mdio_bit};
                    if (bit_cnt_q == 5'd4) begin
                        state_d   = S_TA;
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            rd_strobe_d = 1'b1;
                            shift_d     = bank_q[regad_d];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        first_bit_d = mdio_bit;
                        bit_cnt_d   = 5'd1;
                    end else if (is_read_q) begin
                        state_d   = S_RDATA;
                        bit_cnt_d = '0;
                    end else if (first_bit_q && !mdio_bit) begin
                        state_d   = S_WDATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_SKIP;
                        bit_cnt_d   = 5'd16;
                    end
                end
                S_WDATA: begin
                    shift_d = {shift_q[14:0], mdio_bit};
                    if (bit_cnt_q == 5'd15) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = regad_q;
                        wr_data_d   = shift_d;
                        state_d     = S_PRE;
                        pre_cnt_d   = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                // Station bits during read data are ignored; only bit times count.
                S_RDATA: bit_cnt_d = bit_cnt_q + 5'd1;
                S_SKIP: begin
                    if (bit_cnt_q == 5'd1) begin
                        state_d   = S_PRE;
                        pre_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
                default: state_d = S_PRE;
            endcase
        end else if (mdc_fall) begin
            if (state_q == S_TA && is_read_q && bit_cnt_q == 5'd1) begin
                // Second turnaround bit: take the bus and drive 0.
                mdio_oe_d  = 1'b1;
                mdio_out_d = 1'b0;
            end else if (state_q == S_RDATA) begin
                if (bit_cnt_q == 5'd16) begin
                    mdio_oe_d  = 1'b0;
                    mdio_out_d = 1'b0;
                    state_d    = S_PRE;
                    pre_cnt_d  = '0;
                end else begin
                    mdio_out_d = shift_q[15];
                    shift_d    = {shift_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_PRE;
            mdc_sync_q  <= '0;
            mdio_sync_q <= '0;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            first_bit_q <= 1'b0;
            phyad_q     <= '0;
            regad_q     <= '0;
            shift_q     <= '0;
            mdio_oe_q   <= 1'b0;
            mdio_out_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, independent of statement order.
            state_q     <= state_d;
            mdc_sync_q  <= mdc_sync_d;
            mdio_sync_q <= mdio_sync_d;
            pre_cnt_q   <= pre_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            is_read_q   <= is_read_d;
            first_bit_q <= first_bit_d;
            phyad_q     <= phyad_d;
            regad_q     <= regad_d;
            shift_q     <= shift_d;
            mdio_oe_q   <= mdio_oe_d;
            mdio_out_q  <= mdio_out_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_strobe_q <= rd_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The bank commits one clk after the last data bit, in the WR_STROBE cycle.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            // NOTE: the bank must read as zero after reset, so it is built from
            // resettable flops rather than an uninitialised RAM.
            for (int i = 0; i < 32; i++) bank_q[i] <= '0;
        end else if (wr_strobe_q) begin
            bank_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign MDIO_OUT  = mdio_out_q;
    assign MDIO_OE   = mdio_oe_q;
    assign WR_STROBE = wr_strobe_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign RD_STROBE = rd_strobe_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// -----------------------------------------------------------------------------
// tb_mdio_phy_responder
// Drives MDC/MDIO_IN as a station would (8 clk per MDC phase) into two
// responders: dut0 with the default 32-bit preamble and dut1 with preamble
// suppression. A table of frames with hand-computed outcomes is applied to
// dut0, followed by hand-written preamble and mid-read reset sequences.
// -----------------------------------------------------------------------------
module tb_mdio_phy_responder;

    typedef struct {
        int          pre_len;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
        int          exp_wr;
        int          exp_err;
        int          exp_rd;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic RESET, MDC, MDIO_IN;

    logic        out0, oe0, wrs0, rds0, err0;
    logic [4:0]  wa0;
    logic [15:0] wd0;
    logic        out1, oe1, wrs1, rds1, err1;
    logic [4:0]  wa1;
    logic [15:0] wd1;

    always #5 clk = ~clk;

    mdio_phy_responder dut0 (
        .clk(clk), .RESET(RESET), .MDC(MDC), .MDIO_IN(MDIO_IN),
        .MDIO_OUT(out0), .MDIO_OE(oe0), .WR_STROBE(wrs0), .WR_ADDR(wa0),
        .WR_DATA(wd0), .RD_STROBE(rds0), .FRAME_ERR(err0)
    );

    mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(0)) dut1 (
        .clk(clk), .RESET(RESET), .MDC(MDC), .MDIO_IN(MDIO_IN),
        .MDIO_OUT(out1), .MDIO_OE(oe1), .WR_STROBE(wrs1), .WR_ADDR(wa1),
        .WR_DATA(wd1), .RD_STROBE(rds1), .FRAME_ERR(err1)
    );

    // Pulse and drive-cycle counters per responder.
    int wr_cnt [2] = '{0, 0};
    int rd_cnt [2] = '{0, 0};
    int err_cnt[2] = '{0, 0};
    int oe_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        if (wrs0) wr_cnt[0]  <= wr_cnt[0] + 1;
        if (rds0) rd_cnt[0]  <= rd_cnt[0] + 1;
        if (err0) err_cnt[0] <= err_cnt[0] + 1;
        if (oe0)  oe_cnt[0]  <= oe_cnt[0] + 1;
        if (wrs1) wr_cnt[1]  <= wr_cnt[1] + 1;
        if (rds1) rd_cnt[1]  <= rd_cnt[1] + 1;
        if (err1) err_cnt[1] <= err_cnt[1] + 1;
        if (oe1)  oe_cnt[1]  <= oe_cnt[1] + 1;
    end

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   sel       = 0;
    logic fr_oe  [33];
    logic fr_out [33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    // One MDC period: data set after the fall, MDIO sampled just before the rise.
    task automatic bit_cycle(input logic b, input int idx);
        MDIO_IN = b;
        #80;
        if (idx >= 0) begin
            fr_oe[idx]  = (sel == 1) ? oe1 : oe0;
            fr_out[idx] = (sel == 1) ? out1 : out0;
        end
        MDC = 1'b1;
        #80;
        MDC = 1'b0;
    endtask

    task automatic send_frame(input int pre_len, input logic [31:0] frame);
        for (int i = 0; i < pre_len; i++) bit_cycle(1'b1, -1);
        for (int k = 0; k < 32; k++) bit_cycle(frame[31-k], k);
        bit_cycle(1'b1, 32);
    endtask

    task automatic apply_vec(input vec_t v, input int s, input string tag);
        int          w0, r0, e0, o0;
        logic [15:0] got;
        logic        all_oe;
        sel = s;
        w0 = wr_cnt[s];
        r0 = rd_cnt[s];
        e0 = err_cnt[s];
        o0 = oe_cnt[s];
        send_frame(v.pre_len, {2'b01, v.op, v.phy, v.regad, v.ta, v.data});
        #100;
        check({tag, "_wr_strobes"}, wr_cnt[s] - w0, v.exp_wr);
        check({tag, "_frame_errs"}, err_cnt[s] - e0, v.exp_err);
        check({tag, "_rd_strobes"}, rd_cnt[s] - r0, v.exp_rd);
        if (v.exp_wr != 0) begin
            check({tag, "_wr_addr"}, (s == 1) ? wa1 : wa0, v.regad);
            check({tag, "_wr_data"}, (s == 1) ? wd1 : wd0, v.data);
        end
        if (v.exp_rd != 0) begin
            all_oe = 1'b1;
            for (int i = 0; i < 16; i++) begin
                got[15-i] = fr_out[16+i];
                all_oe    = all_oe & fr_oe[16+i];
            end
            check({tag, "_ta1_oe"}, fr_oe[14], 1'b0);
            check({tag, "_ta2_oe_out"}, {fr_oe[15], fr_out[15]}, 2'b10);
            check({tag, "_rdata"}, got, v.exp_rdata);
            check({tag, "_rdata_oe"}, all_oe, 1'b1);
            check({tag, "_release"}, {fr_oe[32], fr_out[32]}, 2'b00);
        end else begin
            check({tag, "_oe_cycles"}, oe_cnt[s] - o0, 0);
        end
    endtask

    vec_t vecs[9];
    vec_t vx;

    initial begin
        //           pre op     phy    reg     ta     data      wr err rd rdata
        vecs[0] = '{32, 2'b01, 5'd1, 5'd5,  2'b10, 16'hA5C3, 1, 0, 0, 16'h0000};
        vecs[1] = '{32, 2'b10, 5'd1, 5'd5,  2'b11, 16'hFFFF, 0, 0, 1, 16'hA5C3};
        vecs[2] = '{32, 2'b01, 5'd2, 5'd5,  2'b10, 16'h1234, 0, 0, 0, 16'h0000};
        vecs[3] = '{32, 2'b10, 5'd1, 5'd5,  2'b11, 16'hFFFF, 0, 0, 1, 16'hA5C3};
        vecs[4] = '{32, 2'b01, 5'd1, 5'd5,  2'b11, 16'hFFFF, 0, 1, 0, 16'h0000};
        vecs[5] = '{32, 2'b01, 5'd1, 5'd31, 2'b10, 16'h8001, 1, 0, 0, 16'h0000};
        vecs[6] = '{32, 2'b10, 5'd1, 5'd31, 2'b11, 16'hFFFF, 0, 0, 1, 16'h8001};
        vecs[7] = '{32, 2'b10, 5'd1, 5'd0,  2'b11, 16'hFFFF, 0, 0, 1, 16'h0000};
        vecs[8] = '{32, 2'b11, 5'd1, 5'd5,  2'b10, 16'h0000, 0, 0, 0, 16'h0000};

        RESET   = 1'b1;
        MDC     = 1'b0;
        MDIO_IN = 1'b1;
        #20;
        check("reset_outputs", {out0, oe0, wrs0, wa0, wd0, rds0, err0}, 32'd0);
        RESET = 1'b0;
        #40;

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], 0, $sformatf("vec%0d", i));

        // 31 ones is one short: the count is cleared by a 0 first so earlier
        // trailing ones cannot top it up.
        bit_cycle(1'b0, -1);
        vx = '{31, 2'b01, 5'd1, 5'd5, 2'b10, 16'h0F0F, 0, 0, 0, 16'h0000};
        apply_vec(vx, 0, "short_pre");
        vx = '{0, 2'b01, 5'd1, 5'd7, 2'b10, 16'h3C5A, 1, 0, 0, 16'h0000};
        apply_vec(vx, 1, "no_pre");
        vx = '{32, 2'b10, 5'd1, 5'd5, 2'b11, 16'hFFFF, 0, 0, 1, 16'hA5C3};
        apply_vec(vx, 0, "short_pre_bank");

        // Reset during the 8th read data bit of reg 5.
        sel = 0;
        for (int i = 0; i < 32; i++) bit_cycle(1'b1, -1);
        vx.data = {2'b01, 2'b10, 5'd1, 5'd5, 2'b00};
        for (int k = 0; k < 14; k++) bit_cycle(vx.data[15-k], -1);
        for (int k = 0; k < 9; k++) bit_cycle(1'b1, -1);
        MDIO_IN = 1'b1;
        #80;
        check("rst_before_oe", oe0, 1'b1);
        RESET = 1'b1;
        #1;
        check("rst_async_oe", oe0, 1'b0);
        check("rst_outputs", {out0, oe0, wrs0, wa0, wd0, rds0, err0}, 32'd0);
        #29;
        RESET = 1'b0;
        #40;
        vx = '{32, 2'b10, 5'd1, 5'd5, 2'b11, 16'hFFFF, 0, 0, 1, 16'h0000};
        apply_vec(vx, 0, "post_rst_read");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
